// File: rtl/ws2812_arbiter_if.sv
// Requester/driver bundle for the two-port WS2812 write arbiter.
// DUT takes the slave view; the requesters and driver sink take the master view.
interface ws2812_arbiter_if;
    logic        a_req;
    logic        a_valid;
    logic [7:0]  a_led_num;
    logic [23:0] a_rgb;
    logic        a_gnt;
    logic        a_ready;
    logic        b_req;
    logic        b_valid;
    logic [7:0]  b_led_num;
    logic [23:0] b_rgb;
    logic        b_gnt;
    logic        b_ready;
    logic        led_write;
    logic [7:0]  led_num;
    logic [23:0] led_rgb;
    logic        err;

    modport slave (
        input  a_req, a_valid, a_led_num, a_rgb,
        input  b_req, b_valid, b_led_num, b_rgb,
        output a_gnt, a_ready, b_gnt, b_ready,
        output led_write, led_num, led_rgb, err
    );

    modport master (
        output a_req, a_valid, a_led_num, a_rgb,
        output b_req, b_valid, b_led_num, b_rgb,
        input  a_gnt, a_ready, b_gnt, b_ready,
        input  led_write, led_num, led_rgb, err
    );
endinterface

// File: rtl/ws2812_arbiter.sv
// Round-robin two-requester arbiter for a WS2812 pixel write port.
// Optional WS2812_BRIGHTNESS_EN adds a brightness input scaling each colour byte.
module ws2812_arbiter #(
    parameter int NUM_LEDS = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       reset_n,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0] brightness,
`endif
    ws2812_arbiter_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(NUM_LEDS + 1);
    localparam logic [8:0] NL = 9'(NUM_LEDS);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] GRANT_A = 2'b01;
    localparam logic [1:0] GRANT_B = 2'b10;

    logic [1:0]    sync_q;
    logic          rst_ok;
    logic [1:0]    state_q, state_d;
    logic          last_b_q, last_b_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
    logic          led_write_q, err_q;
    logic [7:0]    led_num_q;
    logic [23:0]   led_rgb_q;

    logic          sel_req, sel_valid, xfer, in_range, wr;
    logic [7:0]    sel_num;
    logic [23:0]   sel_rgb, out_rgb;

    // Grants may only start once the deasserted reset has crossed two flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], 1'b1};
    end
    assign rst_ok = sync_q[1];

    assign bus.a_gnt   = state_q[0];
    assign bus.b_gnt   = state_q[1];
    assign bus.a_ready = state_q[0];
    assign bus.b_ready = state_q[1];

    assign sel_req   = state_q[1] ? bus.b_req     : bus.a_req;
    assign sel_num   = state_q[1] ? bus.b_led_num : bus.a_led_num;
    assign sel_rgb   = state_q[1] ? bus.b_rgb     : bus.a_rgb;
    assign sel_valid = (state_q[0] & bus.a_valid) | (state_q[1] & bus.b_valid);
    assign xfer      = sel_valid;
    assign in_range  = {1'b0, sel_num} < NL;
    assign wr        = xfer & in_range;

    assign cnt_inc = cnt_q + CW'(wr);
    assign tmr_inc = xfer ? '0 : tmr_q + TW'(1);

`ifdef WS2812_BRIGHTNESS_EN
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] k);
        logic [15:0] p;
        p = 16'(c) * 16'(k);
        return p[15:8];
    endfunction
    assign out_rgb = {scale(sel_rgb[23:16], brightness),
                      scale(sel_rgb[15:8],  brightness),
                      scale(sel_rgb[7:0],   brightness)};
`else
    assign out_rgb = sel_rgb;
`endif

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        case (state_q)
            IDLE: begin
                // Clearing here means every grant starts with fresh counters.
                cnt_d = '0;
                tmr_d = '0;
                if (rst_ok) begin
                    if (bus.a_req && (!bus.b_req || last_b_q)) begin
                        state_d  = GRANT_A;
                        last_b_d = 1'b0;
                    end else if (bus.b_req) begin
                        state_d  = GRANT_B;
                        last_b_d = 1'b1;
                    end
                end
            end
            GRANT_A, GRANT_B: begin
                cnt_d = cnt_inc;
                tmr_d = tmr_inc;
                if (!sel_req || cnt_inc == CW'(NUM_LEDS) ||
                    tmr_inc == TW'(TIMEOUT))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            cnt_q    <= '0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_write_q <= 1'b0;
            err_q       <= 1'b0;
            led_num_q   <= '0;
            led_rgb_q   <= '0;
        end else begin
            led_write_q <= wr;
            err_q       <= xfer & ~in_range;
            if (wr) begin
                led_num_q <= sel_num;
                led_rgb_q <= out_rgb;
            end
        end
    end

    assign bus.led_write = led_write_q;
    assign bus.err       = err_q;
    assign bus.led_num   = led_num_q;
    assign bus.led_rgb   = led_rgb_q;
endmodule

// File: tb/tb_ws2812_arbiter.sv
// Directed bench for ws2812_arbiter (NUM_LEDS=8, TIMEOUT=4).
// Checks reset, round-robin, burst release, range errors, timeout, async reset.
module tb_ws2812_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ws2812_arbiter_if bus();

    ws2812_arbiter #(.NUM_LEDS(8), .TIMEOUT(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        bus.a_led_num = '0; bus.b_led_num = '0;
        bus.a_rgb = '0; bus.b_rgb = '0;
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.a_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_a_gnt got %b want 0", bus.a_gnt); end
        n_cmp++; if (bus.b_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_b_gnt got %b want 0", bus.b_gnt); end
        n_cmp++; if (bus.led_write !== 1'b0) begin n_bad++; $display("FAIL rst_led_write got %b want 0", bus.led_write); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", bus.err); end
        n_cmp++; if (bus.led_num !== 8'h00) begin n_bad++; $display("FAIL rst_led_num got %h want 00", bus.led_num); end
        n_cmp++; if (bus.led_rgb !== 24'h0) begin n_bad++; $display("FAIL rst_led_rgb got %h want 000000", bus.led_rgb); end
        tick(); tick();
        n_cmp++; if (bus.a_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_hold_gnt got %b want 0", bus.a_gnt); end
        @(negedge clk) reset_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus.a_gnt === 1'b1 || bus.b_gnt === 1'b1) begin
                n = k;
                break;
            end
        end
        n_cmp++; if (n < 2) begin n_bad++; $display("FAIL rst_first_grant_edge got %0d want >=2 (0=none)", n); end
        n_cmp++; if (bus.a_gnt !== 1'b1) begin n_bad++; $display("FAIL cont_first_a got %b want 1", bus.a_gnt); end
        n_cmp++; if (bus.b_gnt !== 1'b0) begin n_bad++; $display("FAIL cont_first_b got %b want 0", bus.b_gnt); end
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL cont_a_ready got %b want 1", bus.a_ready); end
        n_cmp++; if (bus.b_ready !== 1'b0) begin n_bad++; $display("FAIL cont_b_ready got %b want 0", bus.b_ready); end
    endtask

    task automatic test_contention();
        bus.a_req = 1'b0;
        tick();
        n_cmp++; if (bus.a_gnt !== 1'b0) begin n_bad++; $display("FAIL cont_rel_a got %b want 0", bus.a_gnt); end
        n_cmp++; if (bus.b_gnt !== 1'b0) begin n_bad++; $display("FAIL cont_idle_b got %b want 0", bus.b_gnt); end
        tick();
        n_cmp++; if (bus.b_gnt !== 1'b1) begin n_bad++; $display("FAIL cont_b_gnt got %b want 1", bus.b_gnt); end
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL cont_a_ready_b got %b want 0", bus.a_ready); end
        bus.b_req = 1'b0;
        tick();
        n_cmp++; if (bus.b_gnt !== 1'b0) begin n_bad++; $display("FAIL cont_rel_b got %b want 0", bus.b_gnt); end
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        tick();
        n_cmp++; if (bus.a_gnt !== 1'b1) begin n_bad++; $display("FAIL cont_rr_a got %b want 1", bus.a_gnt); end
        n_cmp++; if (bus.b_gnt !== 1'b0) begin n_bad++; $display("FAIL cont_rr_b got %b want 0", bus.b_gnt); end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        tick(); tick();
        n_cmp++; if (bus.a_gnt !== 1'b0) begin n_bad++; $display("FAIL cont_end_a got %b want 0", bus.a_gnt); end
    endtask

    task automatic test_a_only();
        bus.a_req = 1'b1;
        tick();
        n_cmp++; if (bus.a_gnt !== 1'b1) begin n_bad++; $display("FAIL aonly_gnt got %b want 1", bus.a_gnt); end
        for (int i = 0; i < 8; i++) begin
            bus.a_valid = 1'b1;
            bus.a_led_num = 8'(i);
            bus.a_rgb = 24'h0000FF;
            n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL aonly_ready[%0d] got %b want 1", i, bus.a_ready); end
            tick();
            n_cmp++; if (bus.led_write !== 1'b1) begin n_bad++; $display("FAIL aonly_write[%0d] got %b want 1", i, bus.led_write); end
            n_cmp++; if (bus.led_num !== 8'(i)) begin n_bad++; $display("FAIL aonly_num[%0d] got %0d want %0d", i, bus.led_num, i); end
            n_cmp++; if (bus.led_rgb !== 24'h0000FF) begin n_bad++; $display("FAIL aonly_rgb[%0d] got %h want 0000ff", i, bus.led_rgb); end
            n_cmp++; if (bus.a_gnt !== (i < 7)) begin n_bad++; $display("FAIL aonly_hold[%0d] got %b want %b", i, bus.a_gnt, (i < 7)); end
        end
        n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL aonly_ready_after got %b want 0", bus.a_ready); end
        bus.a_valid = 1'b0; bus.a_req = 1'b0;
        tick();
        n_cmp++; if (bus.led_write !== 1'b0) begin n_bad++; $display("FAIL aonly_single_strobe got %b want 0", bus.led_write); end
    endtask

    task automatic test_out_of_range();
        bus.a_req = 1'b1;
        tick();
        n_cmp++; if (bus.a_gnt !== 1'b1) begin n_bad++; $display("FAIL oor_gnt got %b want 1", bus.a_gnt); end
        bus.a_valid = 1'b1; bus.a_led_num = 8'd3; bus.a_rgb = 24'h123456;
        tick();
        n_cmp++; if (bus.led_num !== 8'd3) begin n_bad++; $display("FAIL oor_pre_num got %0d want 3", bus.led_num); end
        bus.a_led_num = 8'd8; bus.a_rgb = 24'hFFFFFF;
        n_cmp++; if (bus.a_ready !== 1'b1) begin n_bad++; $display("FAIL oor_ready got %b want 1", bus.a_ready); end
        tick();
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL oor_err got %b want 1", bus.err); end
        n_cmp++; if (bus.led_write !== 1'b0) begin n_bad++; $display("FAIL oor_write got %b want 0", bus.led_write); end
        n_cmp++; if (bus.led_num !== 8'd3) begin n_bad++; $display("FAIL oor_num_hold got %0d want 3", bus.led_num); end
        n_cmp++; if (bus.led_rgb !== 24'h123456) begin n_bad++; $display("FAIL oor_rgb_hold got %h want 123456", bus.led_rgb); end
        // Seven more writes to one LED: order kept, release exactly at 8 counted.
        for (int j = 0; j < 7; j++) begin
            bus.a_led_num = 8'd2; bus.a_rgb = 24'(j + 16);
            tick();
            n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL oor_err_clr[%0d] got %b want 0", j, bus.err); end
            n_cmp++; if (bus.led_write !== 1'b1) begin n_bad++; $display("FAIL seq_write[%0d] got %b want 1", j, bus.led_write); end
            n_cmp++; if (bus.led_rgb !== 24'(j + 16)) begin n_bad++; $display("FAIL seq_rgb[%0d] got %h want %h", j, bus.led_rgb, 24'(j + 16)); end
            n_cmp++; if (bus.a_gnt !== (j < 6)) begin n_bad++; $display("FAIL oor_count[%0d] gnt got %b want %b", j, bus.a_gnt, (j < 6)); end
        end
        bus.a_valid = 1'b0; bus.a_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bus.a_req = 1'b1;
        tick();
        n_cmp++; if (bus.a_gnt !== 1'b1) begin n_bad++; $display("FAIL to_gnt got %b want 1", bus.a_gnt); end
        bus.b_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++; if (bus.a_gnt !== 1'b1) begin n_bad++; $display("FAIL to_hold[%0d] got %b want 1", k, bus.a_gnt); end
        end
        tick();
        n_cmp++; if (bus.a_gnt !== 1'b0) begin n_bad++; $display("FAIL to_release got %b want 0", bus.a_gnt); end
        n_cmp++; if (bus.b_gnt !== 1'b0) begin n_bad++; $display("FAIL to_idle_b got %b want 0", bus.b_gnt); end
        tick();
        n_cmp++; if (bus.b_gnt !== 1'b1) begin n_bad++; $display("FAIL to_b_gnt got %b want 1", bus.b_gnt); end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_grant();
        bus.a_req = 1'b1;
        tick();
        n_cmp++; if (bus.a_gnt !== 1'b1) begin n_bad++; $display("FAIL mrst_gnt got %b want 1", bus.a_gnt); end
        for (int i = 0; i < 3; i++) begin
            bus.a_valid = 1'b1; bus.a_led_num = 8'(i); bus.a_rgb = 24'h0A0B00 + 24'(i);
            tick();
        end
        n_cmp++; if (bus.led_rgb !== 24'h0A0B02) begin n_bad++; $display("FAIL mrst_pre_rgb got %h want 0a0b02", bus.led_rgb); end
        bus.a_led_num = 8'd3;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.a_gnt !== 1'b0) begin n_bad++; $display("FAIL mrst_a_gnt got %b want 0", bus.a_gnt); end
        n_cmp++; if (bus.led_write !== 1'b0) begin n_bad++; $display("FAIL mrst_write got %b want 0", bus.led_write); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL mrst_err got %b want 0", bus.err); end
        n_cmp++; if (bus.led_rgb !== 24'h0) begin n_bad++; $display("FAIL mrst_rgb got %h want 000000", bus.led_rgb); end
        bus.a_valid = 1'b0; bus.a_req = 1'b0;
        tick();
        @(negedge clk) reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++; if (bus.led_write !== 1'b0) begin n_bad++; $display("FAIL mrst_stray[%0d] got %b want 0", k, bus.led_write); end
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_a_only();
        test_out_of_range();
        test_timeout();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
